// File: rtl/fir_output_sink.sv
// FIR output sink: warm-up discard, quantize/saturate a 64-bit accumulator to 16 bits, show-ahead FIFO.
// Optional macro FIR_OUT_ROUND_EN selects round-half-up instead of floor before saturation.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WARMUP | discarding the first WARMUP valid samples after reset
// ST_RUN    | quantizing samples and buffering them in the output FIFO
module fir_output_sink #(
    parameter int SHIFT  = 15,
    parameter int DEPTH  = 16,
    parameter int WARMUP = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic signed [63:0]       din,
    output logic signed [15:0]       dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              sat_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_t;

    state_t                 state;
    logic [CW-1:0]          disc_cnt;

    logic                   s1_valid;
    logic signed [15:0]     s1_data;

    logic signed [15:0]     mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;

    logic signed [64:0]     din_ext;
    logic signed [64:0]     q_wide;
    logic                   q_hi;
    logic                   q_lo;
    logic signed [15:0]     q_sat;

    logic                   full;
    logic                   pop;
    logic                   push_ok;

`ifdef FIR_OUT_ROUND_EN
    localparam logic signed [64:0] RND = 65'sd1 <<< (SHIFT - 1);
`endif

    // One guard bit above the accumulator so the rounding add cannot wrap.
    always_comb begin
        din_ext = {din[63], din};
`ifdef FIR_OUT_ROUND_EN
        q_wide  = (din_ext + RND) >>> SHIFT;
`else
        q_wide  = din_ext >>> SHIFT;
`endif
        q_hi    = (q_wide > 65'sd32767);
        q_lo    = (q_wide < -65'sd32768);
        if (q_hi) begin
            q_sat = 16'sh7FFF;
        end else if (q_lo) begin
            q_sat = 16'sh8000;
        end else begin
            q_sat = q_wide[15:0];
        end
    end

    assign full       = (count == (AW + 1)'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    assign push_ok    = s1_valid && (!full || pop);
    assign level      = count;
    assign dout       = dout_valid ? mem[rd_ptr] : 16'sd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
            disc_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            sat_count <= '0;
            overflow  <= 1'b0;
        end else begin
            s1_valid <= 1'b0;
            case (state)
                ST_WARMUP: begin
                    if (din_valid) begin
                        disc_cnt <= disc_cnt + CW'(1);
                        if (disc_cnt == CW'(WARMUP - 1)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (din_valid) begin
                        s1_valid <= 1'b1;
                        s1_data  <= q_sat;
                        if ((q_hi || q_lo) && (sat_count != 16'hFFFF)) begin
                            sat_count <= sat_count + 16'd1;
                        end
                    end
                end
                default: state <= ST_WARMUP;
            endcase

            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (s1_valid && full && !pop) begin
                overflow <= 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; dout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= s1_data;
        end
    end

endmodule

// File: tb/tb_fir_output_sink.sv
// Scoreboard bench for fir_output_sink (SHIFT=15, DEPTH=16, WARMUP=8).
// Expected quantized samples are queued at drive time and compared as the DUT pops them.
module tb_fir_output_sink;

    logic                clk;
    logic                rst;
    logic                din_valid;
    logic signed [63:0]  din;
    logic signed [15:0]  dout;
    logic                dout_valid;
    logic                dout_ready;
    logic [4:0]          level;
    logic [15:0]         sat_count;
    logic                overflow;

    int     n_checks;
    int     n_errors;
    longint exp_q[$];

    fir_output_sink #(
        .SHIFT  (15),
        .DEPTH  (16),
        .WARMUP (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .sat_count  (sat_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_queue_empty", longint'(exp_q.size()), 0);
        check_eq("drain_dout_valid", longint'(dout_valid), 0);
    endtask

    // A pop happens at the next rising edge whenever valid && ready are seen here.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_output", longint'(dout), 99999);
            end else begin
                check_eq("dout_order", longint'(dout), exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_level", longint'(level), 0);
        check_eq("rst_dout_valid", longint'(dout_valid), 0);
        check_eq("rst_dout", longint'(dout), 0);
        check_eq("rst_sat_count", longint'(sat_count), 0);
        check_eq("rst_overflow", longint'(overflow), 0);
        rst = 1'b0;
        tick();

        // Warm-up: eight samples vanish, then the ninth appears two edges later.
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(12345);
        tick(); tick(); tick();
        check_eq("warmup_level", longint'(level), 0);
        check_eq("warmup_dout_valid", longint'(dout_valid), 0);
        dout_ready = 1'b0;
        send(163840);
        check_eq("lat_edge1_valid", longint'(dout_valid), 0);
        tick();
        check_eq("lat_edge2_valid", longint'(dout_valid), 1);
        check_eq("lat_edge2_dout", longint'(dout), 5);
        check_eq("lat_edge2_level", longint'(level), 1);
        exp_q.push_back(5);
        dout_ready = 1'b1;
        wait_drain(20);

        // Quantization of values near the half-LSB point.
`ifdef FIR_OUT_ROUND_EN
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(-1);
`else
        exp_q.push_back(0);
        exp_q.push_back(-1);
        exp_q.push_back(-1);
`endif
        send(16384);
        send(-16384);
        send(-16385);
        wait_drain(20);
        check_eq("sat_count_none", longint'(sat_count), 0);

        // Saturation both ways.
        exp_q.push_back(32767);
        exp_q.push_back(-32768);
        send(longint'(1) <<< 40);
        send(-(longint'(1) <<< 40));
        wait_drain(20);
        check_eq("sat_count_two", longint'(sat_count), 2);

        // Fill to DEPTH, then write and pop together for four cycles.
        dout_ready = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            din       = longint'(j) * 32768;
            din_valid = 1'b1;
            exp_q.push_back(j);
            tick();
            if (j == 17) begin
                check_eq("full_level", longint'(level), 16);
                check_eq("full_overflow", longint'(overflow), 0);
                dout_ready = 1'b1;
            end else if (j > 17) begin
                check_eq("wr_pop_level", longint'(level), 16);
            end
        end
        din_valid = 1'b0;
        tick();
        check_eq("wr_pop_level_end", longint'(level), 16);
        check_eq("wr_pop_overflow", longint'(overflow), 0);
        wait_drain(40);

        // Overflow: seventeenth sample dropped, sticky flag set.
        dout_ready = 1'b0;
        for (int j = 1; j <= 17; j++) begin
            if (j <= 16) exp_q.push_back(j);
            send(longint'(j) * 32768);
        end
        tick();
        check_eq("ovf_level", longint'(level), 16);
        check_eq("ovf_flag", longint'(overflow), 1);
        dout_ready = 1'b1;
        wait_drain(40);
        tick(); tick(); tick();
        check_eq("ovf_sticky", longint'(overflow), 1);
        check_eq("ovf_drained_level", longint'(level), 0);

        // Mid-run reset with buffered and in-flight data; rst beats din_valid/dout_ready.
        dout_ready = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            exp_q.push_back(j);
            send(longint'(j) * 32768);
        end
        tick();
        check_eq("pre_rst_level", longint'(level), 5);
        rst        = 1'b1;
        din        = longint'(7) * 32768;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        exp_q.delete();
        tick();
        rst        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        check_eq("mid_rst_level", longint'(level), 0);
        check_eq("mid_rst_dout_valid", longint'(dout_valid), 0);
        check_eq("mid_rst_sat_count", longint'(sat_count), 0);
        check_eq("mid_rst_overflow", longint'(overflow), 0);
        tick(); tick();
        check_eq("post_rst_level", longint'(level), 0);
        check_eq("post_rst_dout_valid", longint'(dout_valid), 0);

        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(longint'(4) * 32768);
        tick(); tick(); tick();
        check_eq("rewarm_level", longint'(level), 0);
        exp_q.push_back(3);
        send(longint'(3) * 32768);
        wait_drain(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
